// File: rtl/ps2_scan_sequencer_if.sv
// Event-side bus of the PS/2 receive sequencer: serial data in, FWFT event
// queue head plus status out. The sequencer takes the slave view; the
// consumer takes the master view.
interface ps2_scan_sequencer_if;
   logic       ps_data;
   logic       evt_rd;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_break;
   logic       evt_ext;
   logic       fifo_full;
   logic       overflow;
   logic       frame_err;
   logic [7:0] err_cnt;

   modport slave (
      input  ps_data,
      input  evt_rd,
      output evt_valid,
      output evt_code,
      output evt_break,
      output evt_ext,
      output fifo_full,
      output overflow,
      output frame_err,
      output err_cnt
   );

   modport master (
      output ps_data,
      output evt_rd,
      input  evt_valid,
      input  evt_code,
      input  evt_break,
      input  evt_ext,
      input  fifo_full,
      input  overflow,
      input  frame_err,
      input  err_cnt
   );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// PS/2 receive sequencer: frame deserialiser with start/parity/stop checks,
// E0/F0 prefix folding into make/break events, and a first-word-fall-through
// event FIFO. Everything runs on the falling edge of the keyboard clock.
//
// Decoder states:
//   state     | meaning
//   ----------+-----------------------------------------------
//   D_IDLE    | no prefix pending
//   D_BRK     | F0 seen, next code is a release
//   D_EXT     | E0 seen, next code is an extended make
//   D_EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_scan_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input logic                ps_clk,
   input logic                rst,
   ps2_scan_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      D_IDLE    = 2'd0,
      D_BRK     = 2'd1,
      D_EXT     = 2'd2,
      D_EXT_BRK = 2'd3
   } dec_state_t;

   localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];
   localparam logic [7:0]     CODE_EXT = 8'hE0;
   localparam logic [7:0]     CODE_BRK = 8'hF0;

   // frame receiver
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic       byte_done;
   logic       byte_good;

   // decoder
   dec_state_t state_q, state_d;
   logic       push;
   logic       push_brk;
   logic       push_ext;
   logic       proto_err;
   logic       err_event;

   // event FIFO, entry = {ext, break, code}
   logic [FIFO_DEPTH-1:0][9:0] mem_q, mem_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]             count_q, count_d;
   logic                       overflow_q, overflow_d;
   logic                       frame_err_q, frame_err_d;
   logic [7:0]                 err_cnt_q, err_cnt_d;
   logic                       empty;
   logic                       full;
   logic                       pop;
   logic                       do_write;
   logic                       drop;
   logic [9:0]                 head;

   // Deserialise one frame; a high level at bit 0 is idle/noise and is skipped.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      byte_done = 1'b0;
      byte_good = 1'b0;
      if (bit_cnt_q == 4'd0) begin
         if (!bus.ps_data) begin
            bit_cnt_d = 4'd1;
         end
      end else if (bit_cnt_q <= 4'd8) begin
         shift_d   = {bus.ps_data, shift_q[7:1]};
         bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
         par_d     = bus.ps_data;
         bit_cnt_d = 4'd10;
      end else begin
         // stop bit: odd parity over data+parity and a high stop make a good byte
         byte_done = 1'b1;
         byte_good = (^{shift_q, par_q}) & bus.ps_data;
         bit_cnt_d = 4'd0;
      end
   end

   // Decoder state register.
   always_ff @(negedge ps_clk or negedge rst) begin
      if (!rst) begin
         state_q <= D_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Decoder next state: prefixes advance, anything else (or any error) returns to idle.
   always_comb begin
      state_d = state_q;
      if (byte_done) begin
         if (!byte_good) begin
            state_d = D_IDLE;
         end else if (shift_q == CODE_EXT) begin
            state_d = (state_q == D_IDLE) ? D_EXT : D_IDLE;
         end else if (shift_q == CODE_BRK) begin
            case (state_q)
               D_IDLE:  state_d = D_BRK;
               D_EXT:   state_d = D_EXT_BRK;
               default: state_d = D_IDLE;
            endcase
         end else begin
            state_d = D_IDLE;
         end
      end
   end

   // Decoder outputs: push a folded event or flag a misplaced prefix.
   always_comb begin
      push      = 1'b0;
      proto_err = 1'b0;
      push_brk  = (state_q == D_BRK) || (state_q == D_EXT_BRK);
      push_ext  = (state_q == D_EXT) || (state_q == D_EXT_BRK);
      if (byte_done && byte_good) begin
         if (shift_q == CODE_EXT) begin
            proto_err = (state_q != D_IDLE);
         end else if (shift_q == CODE_BRK) begin
            proto_err = (state_q == D_BRK) || (state_q == D_EXT_BRK);
         end else begin
            push = 1'b1;
         end
      end
   end

   assign err_event = (byte_done && !byte_good) || proto_err;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_C);
   assign pop      = bus.evt_rd && !empty;
   // when full, a simultaneous pop frees the slot the write lands in
   assign do_write = push && (!full || pop);
   assign drop     = push && full && !pop;

   // FIFO bookkeeping, error counter and sticky status.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_write) begin
         mem_d[wr_ptr_q] = {push_ext, push_brk, shift_q};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_write && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_write && pop) begin
         count_d = count_q - 1'b1;
      end
      overflow_d  = overflow_q | drop;
      frame_err_d = err_event;
      err_cnt_d   = err_cnt_q;
      if (err_event && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Datapath registers; reset discards any partial frame and all queued events.
   always_ff @(negedge ps_clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign head = mem_q[rd_ptr_q];

   assign bus.evt_valid = !empty;
   assign bus.evt_code  = empty ? 8'h00 : head[7:0];
   assign bus.evt_break = empty ? 1'b0  : head[8];
   assign bus.evt_ext   = empty ? 1'b0  : head[9];
   assign bus.fifo_full = full;
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
